datapath: RTL
=============

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 rf_write  input  1  write-back enable from control unit.
REQ-004 rs_addr  input  3  register-file address of operand A.
REQ-005 rt_addr  input  3  register-file address of operand B.
REQ-006 rd_addr  input  3  register-file destination address.
REQ-007 imm_data  input  16  immediate operand.
REQ-008 imm_sel  input  1  1 = operand B is imm_data; 0 = operand B is rf[rt_addr].
REQ-009 alu_sel  input  4  ALU operation select (table in REQ-013).
REQ-010 mem_write  input  1  capture rf[rs_addr] into out_data.
REQ-011 result  output  16  registered ALU result.
REQ-012 zero_flag, pos_flag, out_data  output  1/1/16  registered flags to control unit; registered output port.

Function
REQ-013 The ALU shall decode alu_sel as follows:
- 0000 A+B
- 0001 A-B
- 0010 A&B
- 0011 A|B
- 0100 A^B
- 0101 ~A
- 0110 A<<1
- 0111 A>>1 (logical)
- 1000 A+1
- 1001 A-1
- 1010 A*B (REQ-025)
- 1011 B (MOV/MOVI)
- 1100-1111 16'h0000
REQ-014 All arithmetic shall be 16-bit modulo 2^16; carry/borrow discarded; no overflow flag.
REQ-015 Register-file reads shall be combinational from an 8x16 array; all eight registers are writable (no hardwired zero).
REQ-016 The result register shall load the ALU output on every rising clock edge (execute latency: 1 cycle from stable operands/alu_sel).
REQ-017 When rf_write=1, rf[rd_addr] shall load the current result register value at the rising edge (write-back, 1 cycle after execute).
REQ-018 When rf_write=1, zero_flag shall load (result==0) and pos_flag shall load (result[15]==0 && result!=0) at the same edge; otherwise both flags hold.
REQ-019 Flags shall be evaluated on the pre-edge result register value, not the ALU value computed in that same cycle.
REQ-020 When mem_write=1, out_data shall load rf[rs_addr] at the rising edge; otherwise it holds.
REQ-021 Same-cycle write and read of one address shall return the old value to readers (no bypass); the new value is visible the following cycle.
REQ-022 Simultaneous rf_write and mem_write shall both take effect; out_data receives the pre-write register value.

Reset
REQ-023 While reset=0, all eight registers, result, out_data, zero_flag and pos_flag shall be 0, asynchronously and independent of clock.
REQ-024 Reset asserted mid-operation shall abort any pending write-back; the first edge after release shall load result normally, with no write unless rf_write=1.

Configuration
REQ-025 Macro DATAPATH_MUL_EN: when defined, alu_sel=1010 yields the low 16 bits of unsigned A*B; when undefined, 1010 yields 16'h0000 and no multiplier is synthesised.

Verification
REQ-026 Reset=0 mid-run after R3 loaded -> all registers, result, out_data, flags read 0 immediately, before next clock edge.
REQ-027 imm_sel=1, imm_data=5, alu_sel=1011, then rf_write=1, rd_addr=3 -> result=5 after 1 edge; R3=5, zero=0, pos=1 after 2nd edge.
REQ-028 R1=7, R2=7, alu_sel=0001, rs=1, rt=2, then write-back to R4 -> R4=0, zero_flag=1, pos_flag=0.
REQ-029 R1=16'h0000, alu_sel=1001, write-back to R5 -> R5=16'hFFFF, zero=0, pos=0; then alu_sel=1000 on R5 -> 16'h0000 (wrap).
REQ-030 rf_write=1 to R2 with value 9 and mem_write=1, rs=2 (old R2=4), same edge -> out_data=4, R2=9; next mem_write -> out_data=9.
REQ-031 R1=300, R2=300, alu_sel=1010 -> with DATAPATH_MUL_EN result=16'h5F90 (90000 mod 65536 = 24464); without it result=0.

Source files
------------

// File: rtl/datapath.sv
// Single-cycle 16-bit datapath: 8x16 register file, ALU, registered result/flags/output port.
// Optional multiplier on alu_sel=1010 is enabled by defining DATAPATH_MUL_EN.
module datapath (
  input  logic        clock,
  input  logic        reset,
  input  logic        rf_write,
  input  logic [2:0]  rs_addr,
  input  logic [2:0]  rt_addr,
  input  logic [2:0]  rd_addr,
  input  logic [15:0] imm_data,
  input  logic        imm_sel,
  input  logic [3:0]  alu_sel,
  input  logic        mem_write,
  output logic [15:0] result,
  output logic        zero_flag,
  output logic        pos_flag,
  output logic [15:0] out_data
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_SHL = 4'b0110;
  localparam logic [3:0] ALU_SHR = 4'b0111;
  localparam logic [3:0] ALU_INC = 4'b1000;
  localparam logic [3:0] ALU_DEC = 4'b1001;
  localparam logic [3:0] ALU_MUL = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1011;

  logic [15:0] rf_q [8];
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] result_d;
  logic [15:0] result_q;
  logic [15:0] out_data_q;
  logic        zero_q;
  logic        pos_q;

  // Reads are combinational off the array, so a same-edge write is only seen next cycle.
  assign op_a = rf_q[rs_addr];
  assign op_b = imm_sel ? imm_data : rf_q[rt_addr];

  always_comb begin
    // NOTE: default first so every path assigns result_d and no latch is inferred.
    result_d = 16'h0000;
    case (alu_sel)
      ALU_ADD: result_d = op_a + op_b;
      ALU_SUB: result_d = op_a - op_b;
      ALU_AND: result_d = op_a & op_b;
      ALU_OR:  result_d = op_a | op_b;
      ALU_XOR: result_d = op_a ^ op_b;
      ALU_NOT: result_d = ~op_a;
      ALU_SHL: result_d = op_a << 1;
      ALU_SHR: result_d = op_a >> 1;
      ALU_INC: result_d = op_a + 16'd1;
      ALU_DEC: result_d = op_a - 16'd1;
`ifdef DATAPATH_MUL_EN
      ALU_MUL: result_d = op_a * op_b;
`else
      ALU_MUL: result_d = 16'h0000;
`endif
      ALU_MOV: result_d = op_b;
      default: result_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the register file is cleared by reset, so it is built from flops, not a RAM macro.
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
      result_q   <= 16'h0000;
      out_data_q <= 16'h0000;
      zero_q     <= 1'b0;
      pos_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so write-back, flags and out_data all see pre-edge values.
      result_q <= result_d;
      if (rf_write) begin
        rf_q[rd_addr] <= result_q;
        zero_q        <= (result_q == 16'h0000);
        pos_q         <= !result_q[15] && (result_q != 16'h0000);
      end
      if (mem_write) out_data_q <= rf_q[rs_addr];
    end
  end

  assign result    = result_q;
  assign zero_flag = zero_q;
  assign pos_flag  = pos_q;
  assign out_data  = out_data_q;

endmodule
